// File: rtl/debug_trace_tx.sv
`default_nettype none
// ============================================================================
// Module      : debug_trace_tx
// Description : Hardware trace transmitter for the stack processor. Each
//               instruction-complete pulse captures ROM address, stack top,
//               temp1, temp2 and stack index. The snapshot is then sent as a
//               7-byte UART 8N1 frame on tx:
//                 SYNC_BYTE, a_rom, pilha_dout, temp1, temp2, {0,indice}, xor
//               The checksum is the XOR of bytes 1..5.
//               One snapshot is being sent while a second one can wait in a
//               pending slot. A snapshot that arrives while both are in use
//               is discarded and counted in drop_count, which saturates.
// Ports       : clock       - system clock, rising edge
//               reset       - synchronous active-high reset
//               snap_valid  - capture strobe, one capture per high cycle
//               a_rom       - ROM address (8b)
//               pilha_dout  - stack top (8b)
//               temp1/temp2 - temp registers (8b each)
//               indice      - stack index (4b)
//               tx          - serial output, idle high
//               busy        - high while a frame is being shifted
//               drop_count  - saturating count of lost snapshots
// Revision    : 1.0 - initial release
// ============================================================================
module debug_trace_tx #(
  parameter int         CLKS_PER_BIT = 4,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       snap_valid,
  input  logic [7:0] a_rom,
  input  logic [7:0] pilha_dout,
  input  logic [7:0] temp1,
  input  logic [7:0] temp2,
  input  logic [3:0] indice,
  output logic       tx,
  output logic       busy,
  output logic [7:0] drop_count
);

  localparam int                  c_BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]          c_LAST_BIT  = 3'd7;
  localparam logic [2:0]          c_LAST_BYTE = 3'd6;

  // LOAD is the single cycle between capture and the first start bit.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [39:0]          w_snap;
  logic [39:0]          r_act;
  logic [39:0]          r_pend;
  logic                 r_pend_valid;
  logic [c_BAUD_W-1:0]  r_baud;
  logic [2:0]           r_bit;
  logic [2:0]           r_byte;
  logic [7:0]           r_drop;

  logic                 w_baud_done;
  logic                 w_frame_end;
  logic                 w_chain;
  logic [7:0]           w_cks;
  logic [7:0]           w_cur_byte;

  // Snapshot layout, MSB first: a_rom, pilha_dout, temp1, temp2, {0,indice}
  assign w_snap = {a_rom, pilha_dout, temp1, temp2, 4'b0000, indice};

  assign w_baud_done = (r_baud == c_BAUD_LAST);
  assign w_frame_end = (r_state == ST_STOP) && w_baud_done && (r_byte == c_LAST_BYTE);
  // A new frame follows immediately if something is pending or arriving now.
  assign w_chain     = r_pend_valid || snap_valid;

  assign w_cks = r_act[39:32] ^ r_act[31:24] ^ r_act[23:16] ^ r_act[15:8] ^ r_act[7:0];

  always_comb begin
    w_cur_byte = w_cks;
    case (r_byte)
      3'd0:    w_cur_byte = SYNC_BYTE;
      3'd1:    w_cur_byte = r_act[39:32];
      3'd2:    w_cur_byte = r_act[31:24];
      3'd3:    w_cur_byte = r_act[23:16];
      3'd4:    w_cur_byte = r_act[15:8];
      3'd5:    w_cur_byte = r_act[7:0];
      default: w_cur_byte = w_cks;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and line outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    tx          = 1'b1;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (snap_valid) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_state_nxt = ST_START;
      end
      ST_START: begin
        tx   = 1'b0;
        busy = 1'b1;
        if (w_baud_done) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        tx   = w_cur_byte[r_bit];
        busy = 1'b1;
        if (w_baud_done && (r_bit == c_LAST_BIT)) begin
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        busy = 1'b1;
        if (w_baud_done) begin
          if (r_byte != c_LAST_BYTE) begin
            w_state_nxt = ST_START;
          end else if (w_chain) begin
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Baud, bit and byte counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_baud <= '0;
      r_bit  <= 3'd0;
      r_byte <= 3'd0;
    end else if ((r_state == ST_IDLE) || (r_state == ST_LOAD)) begin
      r_baud <= '0;
      r_bit  <= 3'd0;
      r_byte <= 3'd0;
    end else begin
      r_baud <= w_baud_done ? '0 : (r_baud + c_BAUD_W'(1));
      // Bit counter wraps 7 -> 0 on its own, ready for the next byte.
      if ((r_state == ST_DATA) && w_baud_done) begin
        r_bit <= r_bit + 3'd1;
      end
      if ((r_state == ST_STOP) && w_baud_done) begin
        r_byte <= (r_byte == c_LAST_BYTE) ? 3'd0 : (r_byte + 3'd1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Snapshot buffering: active slot, pending slot, drop counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_act        <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_drop       <= 8'd0;
    end else if (snap_valid) begin
      if (r_state == ST_IDLE) begin
        r_act <= w_snap;
      end else if (w_frame_end) begin
        // The frame is closing this cycle, so a slot frees up: no drop.
        if (r_pend_valid) begin
          r_act  <= r_pend;
          r_pend <= w_snap;
        end else begin
          r_act  <= w_snap;
        end
      end else if (!r_pend_valid) begin
        r_pend       <= w_snap;
        r_pend_valid <= 1'b1;
      end else if (r_drop != 8'hFF) begin
        r_drop <= r_drop + 8'd1;
      end
    end else if (w_frame_end && r_pend_valid) begin
      r_act        <= r_pend;
      r_pend_valid <= 1'b0;
    end
  end

  assign drop_count = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_debug_trace_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_debug_trace_tx
// Description : Directed self-checking bench for debug_trace_tx. A bit-exact
//               UART receiver samples every cycle of every bit and compares
//               each decoded byte with hand-computed frame contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_trace_tx;

  localparam int CPB = 4;

  logic       clock;
  logic       reset;
  logic       snap_valid;
  logic [7:0] a_rom;
  logic [7:0] pilha_dout;
  logic [7:0] temp1;
  logic [7:0] temp2;
  logic [3:0] indice;
  logic       tx;
  logic       busy;
  logic [7:0] drop_count;

  int n_vec;
  int n_bad;

  debug_trace_tx #(
    .CLKS_PER_BIT (CPB),
    .SYNC_BYTE    (8'hA5)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .snap_valid (snap_valid),
    .a_rom      (a_rom),
    .pilha_dout (pilha_dout),
    .temp1      (temp1),
    .temp2      (temp2),
    .indice     (indice),
    .tx         (tx),
    .busy       (busy),
    .drop_count (drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests incomplete");
    $fatal(1, "watchdog");
  end

  // Inputs are driven and outputs sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic [7:0] a, input logic [7:0] p, input logic [7:0] t1,
                       input logic [7:0] t2, input logic [3:0] idx);
    a_rom      = a;
    pilha_dout = p;
    temp1      = t1;
    temp2      = t2;
    indice     = idx;
    snap_valid = 1'b1;
    tick();
    snap_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_start(input string name, input int budget);
    int k;
    k = 0;
    while ((tx !== 1'b0) && (k < budget)) begin
      tick();
      k++;
    end
    n_vec++;
    if (tx !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: no start bit within %0d cycles (tx=%b), required tx=0", name, budget, tx);
    end
  endtask

  // Entered on the first cycle of the start bit of byte 0. Returns on the
  // cycle right after the final stop bit.
  task automatic recv_frame(input string name, input logic [7:0] a, input logic [7:0] p,
                            input logic [7:0] t1, input logic [7:0] t2, input logic [3:0] idx,
                            input logic [7:0] cks, output int busy_cyc);
    logic [7:0] exp_b;
    logic [9:0] bits;
    logic       stable;
    busy_cyc = 0;
    for (int k = 0; k < 7; k++) begin
      case (k)
        0:       exp_b = 8'hA5;
        1:       exp_b = a;
        2:       exp_b = p;
        3:       exp_b = t1;
        4:       exp_b = t2;
        5:       exp_b = {4'b0000, idx};
        default: exp_b = cks;
      endcase
      stable = 1'b1;
      for (int b = 0; b < 10; b++) begin
        bits[b] = tx;
        for (int c = 0; c < CPB; c++) begin
          if (tx !== bits[b]) stable = 1'b0;
          if (busy === 1'b1) busy_cyc++;
          tick();
        end
      end
      n_vec++;
      if ((bits[8:1] !== exp_b) || (bits[0] !== 1'b0) || (bits[9] !== 1'b1) || !stable) begin
        n_bad++;
        $display("FAIL %s byte%0d: got %02h start=%b stop=%b stable=%b, required %02h start=0 stop=1 stable=1",
                 name, k, bits[8:1], bits[0], bits[9], stable, exp_b);
      end
    end
  endtask

  task automatic test_reset();
    logic quiet;
    snap_valid = 1'b0;
    a_rom = 8'h00; pilha_dout = 8'h00; temp1 = 8'h00; temp2 = 8'h00; indice = 4'h0;
    do_reset();
    n_vec++;
    if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b, required 1", tx); end
    n_vec++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_vec++;
    if (drop_count !== 8'd0) begin n_bad++; $display("FAIL reset_drop: got %0d, required 0", drop_count); end
    quiet = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if ((tx !== 1'b1) || (busy !== 1'b0)) quiet = 1'b0;
      tick();
    end
    n_vec++;
    if (!quiet) begin n_bad++; $display("FAIL reset_quiet: activity seen=1, required 0"); end
  endtask

  task automatic test_single();
    int bc;
    do_reset();
    pulse(8'h03, 8'h0F, 8'h05, 8'h0A, 4'h2);
    n_vec++;
    if ((tx !== 1'b1) || (busy !== 1'b0)) begin
      n_bad++; $display("FAIL single_latency1: tx=%b busy=%b, required tx=1 busy=0", tx, busy);
    end
    tick();
    n_vec++;
    if ((tx !== 1'b0) || (busy !== 1'b1)) begin
      n_bad++; $display("FAIL single_latency2: tx=%b busy=%b, required tx=0 busy=1", tx, busy);
    end
    recv_frame("single", 8'h03, 8'h0F, 8'h05, 8'h0A, 4'h2, 8'h01, bc);
    n_vec++;
    if (bc !== 280) begin n_bad++; $display("FAIL single_busy_len: got %0d, required 280", bc); end
    n_vec++;
    if ((busy !== 1'b0) || (tx !== 1'b1)) begin
      n_bad++; $display("FAIL single_end: busy=%b tx=%b, required busy=0 tx=1", busy, tx);
    end
  endtask

  task automatic test_capture();
    int bc;
    do_reset();
    pulse(8'h03, 8'h0F, 8'h05, 8'h0A, 4'h2);
    a_rom = 8'hFF; pilha_dout = 8'hFF; temp1 = 8'hFF; temp2 = 8'hFF; indice = 4'hF;
    wait_start("capture_start", 4);
    recv_frame("capture", 8'h03, 8'h0F, 8'h05, 8'h0A, 4'h2, 8'h01, bc);
  endtask

  task automatic test_pending();
    int bc;
    do_reset();
    pulse(8'h03, 8'h0F, 8'h05, 8'h0A, 4'h2);
    wait_start("pend_start", 4);
    fork
      recv_frame("pend_f1", 8'h03, 8'h0F, 8'h05, 8'h0A, 4'h2, 8'h01, bc);
      begin
        repeat (100) tick();
        pulse(8'h04, 8'h0F, 8'h05, 8'h0A, 4'h2);
      end
    join
    n_vec++;
    if ((tx !== 1'b0) || (busy !== 1'b1)) begin
      n_bad++; $display("FAIL pend_no_gap: tx=%b busy=%b, required tx=0 busy=1", tx, busy);
    end
    recv_frame("pend_f2", 8'h04, 8'h0F, 8'h05, 8'h0A, 4'h2, 8'h06, bc);
    n_vec++;
    if (drop_count !== 8'd0) begin n_bad++; $display("FAIL pend_drop: got %0d, required 0", drop_count); end
    n_vec++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL pend_end_busy: got %b, required 0", busy); end
  endtask

  task automatic test_drop();
    int bc;
    int k;
    do_reset();
    pulse(8'h81, 8'h42, 8'h24, 8'h18, 4'h5);
    wait_start("drop_start", 4);
    fork
      recv_frame("drop_f1", 8'h81, 8'h42, 8'h24, 8'h18, 4'h5, 8'hFA, bc);
      begin
        repeat (30) tick();
        pulse(8'h10, 8'h20, 8'h30, 8'h40, 4'hF);
        repeat (30) tick();
        pulse(8'h77, 8'h77, 8'h77, 8'h77, 4'h7);
      end
    join
    n_vec++;
    if (tx !== 1'b0) begin n_bad++; $display("FAIL drop_no_gap: tx=%b, required 0", tx); end
    recv_frame("drop_f2", 8'h10, 8'h20, 8'h30, 8'h40, 4'hF, 8'h4F, bc);
    n_vec++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL drop_third_lost: busy=%b, required 0", busy); end
    n_vec++;
    if (drop_count !== 8'd1) begin n_bad++; $display("FAIL drop_count1: got %0d, required 1", drop_count); end
    snap_valid = 1'b1;
    repeat (300) tick();
    snap_valid = 1'b0;
    n_vec++;
    if (drop_count !== 8'd255) begin n_bad++; $display("FAIL drop_saturate: got %0d, required 255", drop_count); end
    k = 0;
    while ((busy !== 1'b0) && (k < 1000)) begin
      tick();
      k++;
    end
    n_vec++;
    if ((busy !== 1'b0) || (drop_count !== 8'd255)) begin
      n_bad++; $display("FAIL drop_drain: busy=%b drop=%0d, required busy=0 drop=255", busy, drop_count);
    end
  endtask

  task automatic test_reset_mid();
    int  bc;
    logic quiet;
    do_reset();
    pulse(8'h11, 8'h22, 8'h33, 8'h44, 4'h1);
    wait_start("mid_start", 4);
    repeat (50) tick();
    pulse(8'h55, 8'h66, 8'h77, 8'h88, 4'h2);
    repeat (9) tick();
    pulse(8'h99, 8'hAA, 8'hBB, 8'hCC, 4'h3);
    n_vec++;
    if (drop_count !== 8'd1) begin n_bad++; $display("FAIL mid_predrop: got %0d, required 1", drop_count); end
    repeat (59) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++;
    if ((tx !== 1'b1) || (busy !== 1'b0) || (drop_count !== 8'd0)) begin
      n_bad++; $display("FAIL mid_reset: tx=%b busy=%b drop=%0d, required tx=1 busy=0 drop=0", tx, busy, drop_count);
    end
    quiet = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ((tx !== 1'b1) || (busy !== 1'b0)) quiet = 1'b0;
      tick();
    end
    n_vec++;
    if (!quiet) begin n_bad++; $display("FAIL mid_pending_cleared: activity seen=1, required 0"); end
    pulse(8'hC3, 8'h3C, 8'h01, 8'h80, 4'h9);
    wait_start("mid_restart", 4);
    // C3^3C=FF, ^01=FE, ^80=7E, ^09=77
    recv_frame("mid_clean", 8'hC3, 8'h3C, 8'h01, 8'h80, 4'h9, 8'h77, bc);
    n_vec++;
    if (bc !== 280) begin n_bad++; $display("FAIL mid_busy_len: got %0d, required 280", bc); end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    snap_valid = 1'b0;
    a_rom = 8'h00; pilha_dout = 8'h00; temp1 = 8'h00; temp2 = 8'h00; indice = 4'h0;
    tick();
    test_reset();
    test_single();
    test_capture();
    test_pending();
    test_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
